adc_sclk_gen: RTL



---
 rtl/adc_sclk_gen_if.sv | 29 ++
 rtl/adc_sclk_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sclk_gen_if.sv
// Control/status bundle between the ADC capture controller and adc_sclk_gen.
// master drives the configuration and measurements; slave is the generator.
interface adc_sclk_gen_if #(
  parameter int FREQ_W = 19,
  parameter int SPP_W  = 8,
  parameter int DIV_W  = 24
);
  logic [FREQ_W-1:0] freq_in;
  logic              freq_valid;
  logic [SPP_W-1:0]  spp;
  logic [1:0]        mode;
  logic [DIV_W-1:0]  fixed_div;
  logic              enable;
  logic              sclk;
  logic              sample_stb;
  logic [DIV_W-1:0]  cur_div;
  logic              busy;
  logic              div_err;

  modport master (
    output freq_in, freq_valid, spp, mode, fixed_div, enable,
    input  sclk, sample_stb, cur_div, busy, div_err
  );

  modport slave (
    input  freq_in, freq_valid, spp, mode, fixed_div, enable,
    output sclk, sample_stb, cur_div, busy, div_err
  );
endinterface

// File: rtl/adc_sclk_gen.sv
// Adaptive ADC sample-clock generator: divider = CLK_HZ/(freq*spp) from a
// multi-cycle restoring divider, applied to a near-50% duty clock at period wraps.
module adc_sclk_gen #(
  parameter int CLK_HZ   = 100000000,
  parameter int FREQ_W   = 19,
  parameter int SPP_W    = 8,
  parameter int DIV_W    = 24,
  parameter int DIV_MIN  = 4,
  parameter int DIV_MAX  = 16777215,
  parameter int DIV_INIT = 100
) (
  input  logic         clk_freq,
  input  logic         rstn,
  adc_sclk_gen_if.slave bus
);

  localparam int               PROD_W     = FREQ_W + SPP_W;
  localparam logic [31:0]      CLK_HZ_V   = 32'(CLK_HZ);
  localparam logic [31:0]      DIV_MIN_V  = 32'(DIV_MIN);
  localparam logic [31:0]      DIV_MAX_V  = 32'(DIV_MAX);
  localparam logic [DIV_W-1:0] DIV_INIT_V = DIV_W'(DIV_INIT);
  localparam logic [DIV_W-1:0] ONE_D      = DIV_W'(1);
  localparam logic [1:0]       MODE_ADAPT = 2'b00;
  localparam logic [1:0]       MODE_FIXED = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DIV   = 2'd2,
    ST_CLAMP = 2'd3
  } state_t;

  function automatic logic range_err(input logic [31:0] q);
    return (q < DIV_MIN_V) || (q > DIV_MAX_V);
  endfunction

  function automatic logic [DIV_W-1:0] clamp_div(input logic [31:0] q);
    logic [DIV_W-1:0] res;
    if (q < DIV_MIN_V) begin
      res = DIV_MIN_V[DIV_W-1:0];
    end else if (q > DIV_MAX_V) begin
      res = DIV_MAX_V[DIV_W-1:0];
    end else begin
      res = q[DIV_W-1:0];
    end
    return res;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [FREQ_W-1:0] r_freq;
  logic [SPP_W-1:0]  r_spp;
  logic [PROD_W-1:0] r_prod;
  logic [PROD_W-1:0] r_rem;
  logic [31:0]       r_quo;
  logic [4:0]        r_bit;
  logic              r_busy;
  logic              r_div_err;
  logic [DIV_W-1:0]  r_pending_div;
  logic              r_pending_valid;

  logic [DIV_W-1:0]  r_cur_div;
  logic [DIV_W-1:0]  r_cnt;
  logic              r_sclk;
  logic              r_stb;

  logic              w_accept;
  logic [PROD_W-1:0] w_prod;
  logic              w_prod_zero;
  logic [PROD_W:0]   w_trial;
  logic              w_ge;
  logic [PROD_W-1:0] w_diff;
  logic [PROD_W-1:0] w_rem_nxt;

  logic              w_hold;
  logic [DIV_W-1:0]  w_half;
  logic              w_wrap;
  logic              w_boundary;
  logic              w_take_pending;
  logic              w_take_fixed;
  logic              w_pend_set;

  assign w_accept    = (r_state == ST_IDLE) && bus.freq_valid && (bus.mode == MODE_ADAPT);
  assign w_prod      = PROD_W'(r_freq) * PROD_W'(r_spp);
  assign w_prod_zero = (w_prod == {PROD_W{1'b0}});

  // One restoring step: shift in the next numerator bit, subtract if it fits.
  // The subtraction is done modulo 2^PROD_W; when w_ge holds the true result is < r_prod.
  assign w_trial   = {r_rem, CLK_HZ_V[r_bit]};
  assign w_ge      = (w_trial >= {1'b0, r_prod});
  assign w_diff    = w_trial[PROD_W-1:0] - r_prod;
  assign w_rem_nxt = w_ge ? w_diff : w_trial[PROD_W-1:0];

  // Computation FSM state register.
  always_ff @(posedge clk_freq or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Computation FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_MUL;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (w_prod_zero) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DIV;
        end
      end
      ST_DIV: begin
        if (r_bit == 5'd0) begin
          w_state_nxt = ST_CLAMP;
        end else begin
          w_state_nxt = ST_DIV;
        end
      end
      ST_CLAMP: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, product, divider datapath and result/error registers.
  always_ff @(posedge clk_freq or negedge rstn) begin
    if (!rstn) begin
      r_freq        <= {FREQ_W{1'b0}};
      r_spp         <= {SPP_W{1'b0}};
      r_prod        <= {PROD_W{1'b0}};
      r_rem         <= {PROD_W{1'b0}};
      r_quo         <= 32'd0;
      r_bit         <= 5'd0;
      r_busy        <= 1'b0;
      r_div_err     <= 1'b0;
      r_pending_div <= DIV_INIT_V;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_freq <= bus.freq_in;
            r_spp  <= bus.spp;
            r_busy <= 1'b1;
          end
        end
        ST_MUL: begin
          r_prod <= w_prod;
          r_rem  <= {PROD_W{1'b0}};
          r_quo  <= 32'd0;
          r_bit  <= 5'd31;
          if (w_prod_zero) begin
            r_div_err <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        ST_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= {r_quo[30:0], w_ge};
          r_bit <= r_bit - 5'd1;
        end
        ST_CLAMP: begin
          r_pending_div <= clamp_div(r_quo);
          r_div_err     <= range_err(r_quo);
          r_busy        <= 1'b0;
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  // Divider updates happen only at a wrap while running, so sclk phases never shrink;
  // when disabled the output is parked low and updates take effect immediately.
  assign w_hold         = bus.mode[1];
  assign w_half         = r_cur_div >> 1;
  assign w_wrap         = (r_cnt >= (r_cur_div - ONE_D));
  assign w_boundary     = bus.enable ? w_wrap : 1'b1;
  assign w_take_pending = w_boundary && (bus.mode == MODE_ADAPT) && r_pending_valid;
  assign w_take_fixed   = w_boundary && (bus.mode == MODE_FIXED);
  assign w_pend_set     = (r_state == ST_CLAMP);

  // Period counter, registered sclk/strobe, active divider and pending flag.
  always_ff @(posedge clk_freq or negedge rstn) begin
    if (!rstn) begin
      r_cnt           <= {DIV_W{1'b0}};
      r_sclk          <= 1'b0;
      r_stb           <= 1'b0;
      r_cur_div       <= DIV_INIT_V;
      r_pending_valid <= 1'b0;
    end else begin
      if (bus.enable) begin
        r_sclk <= (r_cnt < w_half);
        r_stb  <= (r_cnt == {DIV_W{1'b0}});
        r_cnt  <= w_wrap ? {DIV_W{1'b0}} : (r_cnt + ONE_D);
      end else begin
        r_sclk <= 1'b0;
        r_stb  <= 1'b0;
        r_cnt  <= {DIV_W{1'b0}};
      end

      if (w_take_fixed) begin
        r_cur_div <= clamp_div(32'(bus.fixed_div));
      end else if (w_take_pending) begin
        r_cur_div <= r_pending_div;
      end else begin
        r_cur_div <= r_cur_div;
      end

      // A fresh result wins over the clear, so one landing on a wrap waits a period.
      if (w_pend_set && !w_hold) begin
        r_pending_valid <= 1'b1;
      end else if (w_take_pending || w_hold) begin
        r_pending_valid <= 1'b0;
      end else begin
        r_pending_valid <= r_pending_valid;
      end
    end
  end

  assign bus.sclk       = r_sclk;
  assign bus.sample_stb = r_stb;
  assign bus.cur_div    = r_cur_div;
  assign bus.busy       = r_busy;
  assign bus.div_err    = r_div_err;

endmodule
